// File: rtl/qubit_measure.sv
// ---------------------------------------------------------------------------
// qubit_measure
//   Single-qubit projective measurement at the end of a gate chain.
//   Accepts one amplitude pair (alpha, beta) in signed Q2.14 and computes
//   |alpha|^2 and |beta|^2. It compares a 16-bit LFSR sample against the
//   outcome probability without dividing, and returns the measured bit plus
//   the collapsed state. Global phase is dropped, so 1.0 = 16'h4000 + j0.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             input handshake (ready only in IDLE)
//   alpha_re/im, beta_re/im [15:0]  input amplitudes, signed Q2.14
//   out_valid / out_ready           output handshake (valid only in DONE)
//   meas_bit                        0 = |0>, 1 = |1>
//   norm_err                        input had |alpha|^2 + |beta|^2 == 0
//   out_alpha_re/im, out_beta_re/im collapsed state, Q2.14
//
// Optional build macro
//   QMEAS_SEED_LOAD_EN : adds seed_load / seed [15:0] for reseeding the LFSR
//                        (seed 0 is replaced by 16'hACE1).
//
// Timing: an input accepted on edge N gives out_valid after edge N+4.
// The states are SQ, SUM, and two CMP cycles. The first CMP cycle registers
// the 16x34 product, so that the multiplier and the 50-bit compare sit in
// separate cycles.
// ---------------------------------------------------------------------------
module qubit_measure (
    input  logic        clk,
    input  logic        rst_n,
`ifdef QMEAS_SEED_LOAD_EN
    input  logic        seed_load,
    input  logic [15:0] seed,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] alpha_re,
    input  logic [15:0] alpha_im,
    input  logic [15:0] beta_re,
    input  logic [15:0] beta_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        meas_bit,
    output logic        norm_err,
    output logic [15:0] out_alpha_re,
    output logic [15:0] out_alpha_im,
    output logic [15:0] out_beta_re,
    output logic [15:0] out_beta_im
);

    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [15:0] ONE_Q214  = 16'h4000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ,
        S_SUM,
        S_CMP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Lane order: 0 = alpha_re, 1 = alpha_im, 2 = beta_re, 3 = beta_im
    logic [3:0][15:0] amp_q;
    logic [3:0][31:0] sq_d, sq_q;
    logic [15:0]      rnd_q;
    logic [15:0]      lfsr_q, lfsr_d, lfsr_step;
    logic [32:0]      p0_d, p1_d, p0_q;
    logic [33:0]      total_d, total_q;
    logic [49:0]      prod_q;
    logic             cmp_ph_q;
    logic             accept;
    logic             meas_d;
    logic             zero_d;

    assign accept = (state_q == S_IDLE) && in_valid;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_SQ;
            end
            S_SQ:  state_d = S_SUM;
            S_SUM: state_d = S_CMP;
            S_CMP: if (cmp_ph_q) state_d = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- squares ----------------
    // The signed square is never negative. Its largest value, (-2.0)^2 =
    // 2^30, fits in 32 unsigned bits, so the signed result can be reused
    // as an unsigned value.
    for (genvar i = 0; i < 4; i++) begin : g_sq
        logic signed [31:0] sq_s;
        assign sq_s    = $signed(amp_q[i]) * $signed(amp_q[i]);
        assign sq_d[i] = sq_s;
    end

    assign p0_d    = {1'b0, sq_q[0]} + {1'b0, sq_q[1]};
    assign p1_d    = {1'b0, sq_q[2]} + {1'b0, sq_q[3]};
    assign total_d = {1'b0, p0_d} + {1'b0, p1_d};

    // outcome 0 iff rnd * total < p0 * 2^16, i.e. rnd/2^16 < p0/total
    assign zero_d = (total_q == 34'd0);
    assign meas_d = zero_d ? 1'b0 : !(prod_q < {1'b0, p0_q, 16'd0});

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amp_q        <= '0;
            rnd_q        <= '0;
            sq_q         <= '0;
            p0_q         <= '0;
            total_q      <= '0;
            prod_q       <= '0;
            cmp_ph_q     <= 1'b0;
            meas_bit     <= 1'b0;
            norm_err     <= 1'b0;
            out_alpha_re <= '0;
            out_beta_re  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    amp_q <= {beta_im, beta_re, alpha_im, alpha_re};
                    rnd_q <= lfsr_q;
                end
                S_SQ: sq_q <= sq_d;
                S_SUM: begin
                    p0_q    <= p0_d;
                    total_q <= total_d;
                end
                S_CMP: begin
                    if (!cmp_ph_q) begin
                        prod_q   <= {34'd0, rnd_q} * {16'd0, total_q};
                        cmp_ph_q <= 1'b1;
                    end else begin
                        cmp_ph_q     <= 1'b0;
                        meas_bit     <= meas_d;
                        norm_err     <= zero_d;
                        out_alpha_re <= meas_d ? 16'd0 : ONE_Q214;
                        out_beta_re  <= meas_d ? ONE_Q214 : 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The collapsed state is always real, so the imaginary parts are
    // constant zero.
    assign out_alpha_im = 16'd0;
    assign out_beta_im  = 16'd0;

    // ---------------- LFSR ----------------
    // x^16+x^14+x^13+x^11+1, shifting right. It steps only on an accepted
    // input, so the result sequence depends only on the sequence of inputs.
    assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) lfsr_d = lfsr_step;
`ifdef QMEAS_SEED_LOAD_EN
        // An all-zero state would lock the LFSR up.
        if (seed_load) lfsr_d = (seed == 16'd0) ? LFSR_INIT : seed;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_INIT;
        else        lfsr_q <= lfsr_d;
    end

endmodule

// File: tb/tb_qubit_measure.sv
`timescale 1ns/1ps
module tb_qubit_measure;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] alpha_re = '0, alpha_im = '0, beta_re = '0, beta_im = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        meas_bit, norm_err;
    logic [15:0] out_alpha_re, out_alpha_im, out_beta_re, out_beta_im;
`ifdef QMEAS_SEED_LOAD_EN
    logic        seed_load = 1'b0;
    logic [15:0] seed = '0;
`endif

    qubit_measure dut (
        .clk(clk), .rst_n(rst_n),
`ifdef QMEAS_SEED_LOAD_EN
        .seed_load(seed_load), .seed(seed),
`endif
        .in_valid(in_valid), .in_ready(in_ready),
        .alpha_re(alpha_re), .alpha_im(alpha_im), .beta_re(beta_re), .beta_im(beta_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .meas_bit(meas_bit), .norm_err(norm_err),
        .out_alpha_re(out_alpha_re), .out_alpha_im(out_alpha_im),
        .out_beta_re(out_beta_re), .out_beta_im(out_beta_im)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        meas;
        logic        nerr;
        logic [15:0] ar, ai, br, bi;
    } res_t;

    res_t        sb[$];
    logic [15:0] lfsr_m = 16'hACE1;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic res_t model(input logic [15:0] ar, ai, br, bi, input logic [15:0] rnd);
        longint p0, p1, tot;
        res_t r;
        p0 = longint'($signed(ar)) * longint'($signed(ar)) + longint'($signed(ai)) * longint'($signed(ai));
        p1 = longint'($signed(br)) * longint'($signed(br)) + longint'($signed(bi)) * longint'($signed(bi));
        tot = p0 + p1;
        r = '0;
        if (tot == 0) r.nerr = 1'b1;
        else          r.meas = !((longint'(rnd) * tot) < (p0 * 65536));
        if (r.meas) r.br = 16'h4000;
        else        r.ar = 16'h4000;
        return r;
    endfunction

    // Drive a pair, wait for acceptance, push the expected result.
    // Returns #1 after the accepting edge.
    task automatic send(input logic [15:0] ar, ai, br, bi);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        alpha_re = ar; alpha_im = ai; beta_re = br; beta_im = bi;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept_wait", in_ready, 1'b1);
        sb.push_back(model(ar, ai, br, bi, lfsr_m));
        lfsr_m = step(lfsr_m);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for a result, compare it with the scoreboard head, then handshake.
    task automatic recv(input string tag);
        int n = 0;
        res_t e;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, out_valid, 1'b1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_meas"}, meas_bit, e.meas);
            chk({tag, "_nerr"}, norm_err, e.nerr);
            chk({tag, "_state"}, {out_alpha_re, out_alpha_im, out_beta_re, out_beta_im},
                {e.ar, e.ai, e.br, e.bi});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_hs_valid_low"}, out_valid, 1'b0);
        chk({tag, "_hs_ready_high"}, in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   n;
        res_t e;

        // ---- reset ----
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_meas", meas_bit, 1'b0);
        chk("rst_nerr", norm_err, 1'b0);
        chk("rst_amps", {out_alpha_re, out_alpha_im, out_beta_re, out_beta_im}, 64'd0);
        rst_n = 1'b1;

        // ---- equal superposition from reset: rnd 0xACE1 -> 1, 0x5670 -> 0 ----
        send(16'h2D41, 16'h0000, 16'h2D41, 16'h0000);
        recv("sup1");
        chk("sup1_spec", meas_bit, 1'b1);
        send(16'h2D41, 16'h0000, 16'h2D41, 16'h0000);
        recv("sup2");
        chk("sup2_spec", meas_bit, 1'b0);

        // ---- |0> ten times with latency check ----
        for (int k = 0; k < 10; k++) begin
            send(16'h4000, 16'h0000, 16'h0000, 16'h0000);
            lat = 0;
            while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            chk("zero_latency", lat, 4);
            recv("zero_state");
        end

        // ---- |1> given as -1.0j on beta ----
        send(16'h0000, 16'h0000, 16'h0000, 16'hC000);
        recv("one_state");
        chk("one_spec", {meas_bit, out_beta_re, out_beta_im}, {1'b1, 16'h4000, 16'h0000});

        // ---- negative components in superposition ----
        send(16'hD2BF, 16'h0000, 16'h0000, 16'hD2BF);
        recv("neg_sup");
        send(16'h0000, 16'hC000, 16'h0000, 16'h0000);
        recv("neg_alpha");
        chk("neg_alpha_spec", meas_bit, 1'b0);

        // ---- all-zero amplitudes ----
        send(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        recv("zero_amp");
        chk("zero_amp_spec", {norm_err, meas_bit, out_alpha_re}, {1'b1, 1'b0, 16'h4000});

        // ---- backpressure with a second input waiting ----
        out_ready = 1'b0;
        send(16'h0000, 16'h0000, 16'h4000, 16'h0000);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("bp_valid", out_valid, 1'b1);
        e = sb.pop_front();
        in_valid = 1'b1;
        alpha_re = 16'h4000; alpha_im = '0; beta_re = '0; beta_im = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_meas", meas_bit, e.meas);
            chk("bp_state", {out_alpha_re, out_beta_re}, {e.ar, e.br});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_valid_low", out_valid, 1'b0);
        chk("bp_hs_ready_high", in_ready, 1'b1);
        sb.push_back(model(16'h4000, 16'h0000, 16'h0000, 16'h0000, lfsr_m));
        lfsr_m = step(lfsr_m);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_taken", in_ready, 1'b0);
        recv("bp_second");

        // ---- reset during SUM ----
        send(16'h2D41, 16'h0000, 16'h2D41, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_amps", {out_alpha_re, out_beta_re, meas_bit}, 33'd0);
        void'(sb.pop_back());
        lfsr_m = 16'hACE1;
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h2D41, 16'h0000, 16'h2D41, 16'h0000);
        recv("midrst_sup1");
        chk("midrst_sup1_spec", meas_bit, 1'b1);
        send(16'h2D41, 16'h0000, 16'h2D41, 16'h0000);
        recv("midrst_sup2");
        chk("midrst_sup2_spec", meas_bit, 1'b0);

`ifdef QMEAS_SEED_LOAD_EN
        // ---- seed load ----
        @(negedge clk);
        seed = 16'hFFFF; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        lfsr_m = 16'hFFFF;
        send(16'h2D41, 16'h0000, 16'h2D41, 16'h0000);
        recv("seed_ffff");
        chk("seed_ffff_spec", meas_bit, 1'b1);
        @(negedge clk);
        seed = 16'h0000; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        lfsr_m = 16'hACE1;
        send(16'h2D41, 16'h0000, 16'h2D41, 16'h0000);
        recv("seed_zero1");
        send(16'h2D41, 16'h0000, 16'h2D41, 16'h0000);
        recv("seed_zero2");
        chk("seed_zero2_spec", meas_bit, 1'b0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
